// File: rtl/matrix_mopa_ctrl.sv
// matrix_mopa_ctrl: sole writer of the 4x32 matrix register file.
// It arbitrates between scalar row writes and MOPA commands. A MOPA is
// computed one row per cycle into a staging buffer, and all four rows are
// committed in a single strobe.
module matrix_mopa_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [1:0]       s_index,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    input  logic             m_valid,
    input  logic [31:0]      m_a,
    input  logic [31:0]      m_b,
    input  logic             m_acc,
    output logic             m_ready,
    output logic             m_busy,
    output logic             m_done,
    input  logic [3:0][31:0] M_in,
    output logic [1:0]       w_matrix_index,
    output logic [31:0]      w_matrix_data,
    output logic             w_matrix_en,
    output logic [3:0][31:0] w_matrix_data_mopa,
    output logic             w_matrix_en_mopa
);

    typedef enum logic [1:0] {IDLE, SWR, CALC, COMMIT} state_t;

    localparam logic GRANT_S = 1'b0;
    localparam logic GRANT_M = 1'b1;

    state_t           r_state;
    logic [1:0]       r_row;
    logic             r_last;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_acc;
    logic [1:0]       r_idx;
    logic [31:0]      r_data;
    logic             r_wen;
    logic             r_wen_mopa;
    logic             r_busy;
    logic             r_done;
    logic [3:0][31:0] r_stage;

    logic             w_idle;
    logic             w_s_grant;
    logic             w_m_grant;
    logic [7:0]       w_a_byte;
    logic [3:0][15:0] w_prod;
    logic [31:0]      w_base;
    logic [31:0]      w_row;

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        w_idle    = (r_state == IDLE);
        w_s_grant = w_idle && s_valid && (!m_valid || (r_last == GRANT_M));
        w_m_grant = w_idle && m_valid && (!s_valid || (r_last == GRANT_S));
    end

    // Row r of the outer product plus an optional M_in accumulate.
    // Each byte lane wraps mod 256 on its own, with no carry between lanes.
    always_comb begin
        w_prod   = '0;
        w_base   = '0;
        w_row    = '0;
        w_a_byte = r_a[{r_row, 3'b000} +: 8];
        for (int j = 0; j < 4; j++) begin
            w_prod[j]        = 16'(w_a_byte) * 16'(r_b[8*j +: 8]);
            w_base[8*j +: 8] = r_acc ? M_in[r_row][8*j +: 8] : 8'h00;
            w_row[8*j +: 8]  = w_base[8*j +: 8] + w_prod[j][7:0];
        end
    end

    // Control FSM. Strobes are registered, and reset discards any in-flight
    // operation without emitting a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= 2'd0;
            r_last     <= GRANT_M;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= 1'b0;
            r_idx      <= 2'd0;
            r_data     <= '0;
            r_wen      <= 1'b0;
            r_wen_mopa <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stage    <= '0;
        end else begin
            r_wen      <= 1'b0;
            r_wen_mopa <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s_grant) begin
                        r_idx   <= s_index;
                        r_data  <= s_data;
                        r_last  <= GRANT_S;
                        r_wen   <= 1'b1;
                        r_state <= SWR;
                    end else if (w_m_grant) begin
                        r_a     <= m_a;
                        r_b     <= m_b;
                        r_acc   <= m_acc;
                        r_row   <= 2'd0;
                        r_last  <= GRANT_M;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                SWR: begin
                    r_state <= IDLE;
                end
                CALC: begin
                    r_stage[r_row] <= w_row;
                    r_row          <= r_row + 2'd1;
                    if (r_row == 2'd3) begin
                        r_wen_mopa <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready            = w_s_grant;
    assign m_ready            = w_m_grant;
    assign m_busy             = r_busy;
    assign m_done             = r_done;
    assign w_matrix_index     = r_idx;
    assign w_matrix_data      = r_data;
    assign w_matrix_en        = r_wen;
    assign w_matrix_data_mopa = r_stage;
    assign w_matrix_en_mopa   = r_wen_mopa;

endmodule

// File: tb/tb_matrix_mopa_ctrl.sv
// Bench for matrix_mopa_ctrl. It models the register file and checks each
// transaction against a transaction-level matrix model.
module tb_matrix_mopa_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic [1:0]       s_index;
    logic [31:0]      s_data;
    logic             s_ready;
    logic             m_valid;
    logic [31:0]      m_a;
    logic [31:0]      m_b;
    logic             m_acc;
    logic             m_ready;
    logic             m_busy;
    logic             m_done;
    logic [3:0][31:0] M_in;
    logic [1:0]       w_matrix_index;
    logic [31:0]      w_matrix_data;
    logic             w_matrix_en;
    logic [3:0][31:0] w_matrix_data_mopa;
    logic             w_matrix_en_mopa;

    logic [3:0][31:0] rf = '0;
    logic [3:0][31:0] mdl = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mopa_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_index(s_index), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_a(m_a), .m_b(m_b), .m_acc(m_acc),
        .m_ready(m_ready), .m_busy(m_busy), .m_done(m_done),
        .M_in(M_in),
        .w_matrix_index(w_matrix_index), .w_matrix_data(w_matrix_data),
        .w_matrix_en(w_matrix_en),
        .w_matrix_data_mopa(w_matrix_data_mopa), .w_matrix_en_mopa(w_matrix_en_mopa)
    );

    // Register file written only through the controller's strobes.
    always @(posedge clk) begin
        if (w_matrix_en) rf[w_matrix_index] <= w_matrix_data;
        if (w_matrix_en_mopa) rf <= w_matrix_data_mopa;
    end
    assign M_in = rf;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    // Outer product from the definition: M'[i][j] = (acc ? M[i][j] : 0) + a_i*b_j mod 256.
    function automatic logic [3:0][31:0] mopa_ref(input logic [3:0][31:0] cur,
                                                   input logic [31:0] a, input logic [31:0] b,
                                                   input logic acc);
        logic [3:0][31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int v;
                v = (acc ? int'(cur[i][8*j +: 8]) : 0) + int'(a[8*i +: 8]) * int'(b[8*j +: 8]);
                res[i][8*j +: 8] = 8'(v % 256);
            end
        return res;
    endfunction

    task automatic wait_ready(input bit want_m, input string tag);
        int n = 0;
        #1;
        while (!(want_m ? m_ready : s_ready) && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, n < 40, 1'b1);
    endtask

    // Cycles T+1..T+6 after a MOPA handshake.
    task automatic mopa_tail(input logic [3:0][31:0] ex, input string tag);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, m_busy, 1'b1);
            chk({tag, "_done"}, m_done, k == 5);
            chk({tag, "_en_mopa"}, w_matrix_en_mopa, k == 5);
            chk({tag, "_no_swr"}, w_matrix_en, 1'b0);
            chk({tag, "_rdy"}, {s_ready, m_ready}, 2'b00);
            if (k == 5) chk({tag, "_data"}, w_matrix_data_mopa, ex);
        end
        @(negedge clk);
        chk({tag, "_busy_off"}, m_busy, 1'b0);
        chk({tag, "_done_off"}, m_done, 1'b0);
        chk({tag, "_rf"}, rf, ex);
        mdl = ex;
    endtask

    task automatic mopa(input logic [31:0] a, input logic [31:0] b, input logic acc,
                        input string tag);
        logic [3:0][31:0] ex;
        ex = mopa_ref(mdl, a, b, acc);
        @(negedge clk);
        m_a = a; m_b = b; m_acc = acc; m_valid = 1'b1;
        wait_ready(1'b1, {tag, "_grant"});
        @(posedge clk); #1;
        m_valid = 1'b0;
        mopa_tail(ex, tag);
    endtask

    // Cycles T+1..T+2 after a scalar handshake.
    task automatic swr_tail(input logic [1:0] idx, input logic [31:0] d, input string tag);
        @(negedge clk);
        chk({tag, "_en"}, w_matrix_en, 1'b1);
        chk({tag, "_idx"}, w_matrix_index, idx);
        chk({tag, "_data"}, w_matrix_data, d);
        chk({tag, "_no_mopa"}, w_matrix_en_mopa, 1'b0);
        chk({tag, "_rdy"}, s_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_en_off"}, w_matrix_en, 1'b0);
        mdl[idx] = d;
        chk({tag, "_rf"}, rf, mdl);
    endtask

    task automatic swr(input logic [1:0] idx, input logic [31:0] d, input string tag);
        @(negedge clk);
        s_index = idx; s_data = d; s_valid = 1'b1;
        wait_ready(1'b0, {tag, "_grant"});
        @(posedge clk); #1;
        s_valid = 1'b0;
        swr_tail(idx, d, tag);
    endtask

    initial begin
        logic [3:0][31:0] ex;
        logic [31:0] x, y, ra, rb;
        rst = 1'b1; s_valid = 1'b0; s_index = 2'd0; s_data = '0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_en", w_matrix_en, 1'b0);
        chk("rst_en_mopa", w_matrix_en_mopa, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_idx", w_matrix_index, 2'd0);
        chk("rst_data", w_matrix_data, 32'd0);
        chk("rst_stage", w_matrix_data_mopa, 128'd0);
        chk("rst_rdy", {s_ready, m_ready}, 2'b00);

        // First tie after reset goes to the scalar requester, then the MOPA (overwrite)
        s_valid = 1'b1; s_index = 2'd2; s_data = 32'hDEADBEEF;
        m_valid = 1'b1; m_a = 32'h04030201; m_b = 32'h01010101; m_acc = 1'b0;
        #1;
        chk("tie1_s_rdy", s_ready, 1'b1);
        chk("tie1_m_rdy", m_ready, 1'b0);
        @(posedge clk); #1 s_valid = 1'b0;
        swr_tail(2'd2, 32'hDEADBEEF, "tie1_swr");
        #1 chk("tie1_m_rdy2", m_ready, 1'b1);
        ex = mopa_ref(mdl, 32'h04030201, 32'h01010101, 1'b0);
        @(posedge clk); #1 m_valid = 1'b0;
        mopa_tail(ex, "ovr");
        chk("ovr_const", rf, {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101});

        // Accumulate
        mopa(32'h04030201, 32'h01010101, 1'b1, "acc");
        chk("acc_const", rf, {32'h08080808, 32'h06060606, 32'h04040404, 32'h02020202});

        // Lone scalar, then a second tie: MOPA wins, scalar waits
        swr(2'd1, $urandom, "lone");
        x = $urandom;
        ex = mopa_ref(mdl, 32'h0000000F, 32'h00000011, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_index = 2'd3; s_data = x;
        m_valid = 1'b1; m_a = 32'h0000000F; m_b = 32'h00000011; m_acc = 1'b0;
        #1;
        chk("tie2_m_rdy", m_ready, 1'b1);
        chk("tie2_s_rdy", s_ready, 1'b0);
        @(posedge clk); #1 m_valid = 1'b0;
        mopa_tail(ex, "wrap1");
        chk("wrap1_row0", rf[0], 32'h000000FF);
        #1 chk("tie2_s_rdy2", s_ready, 1'b1);
        @(posedge clk); #1 s_valid = 1'b0;
        swr_tail(2'd3, x, "tie2_swr");

        // Wrap-around accumulate
        mopa(32'h00000001, 32'h00000001, 1'b1, "wrap2");
        chk("wrap2_row0", rf[0], 32'h00000000);
        chk("wrap2_row3", rf[3], x);

        // Scalar request held across a MOPA waits and lands after the commit
        ra = $urandom; rb = $urandom; y = $urandom;
        ex = mopa_ref(mdl, ra, rb, 1'b1);
        @(negedge clk);
        m_a = ra; m_b = rb; m_acc = 1'b1; m_valid = 1'b1;
        wait_ready(1'b1, "blk_grant");
        @(posedge clk); #1;
        m_valid = 1'b0;
        s_valid = 1'b1; s_index = 2'd1; s_data = y;
        mopa_tail(ex, "blk");
        #1 chk("blk_s_rdy", s_ready, 1'b1);
        @(posedge clk); #1 s_valid = 1'b0;
        swr_tail(2'd1, y, "blk_swr");

        // Reset during CALC aborts the MOPA without any strobe
        @(negedge clk);
        m_a = $urandom; m_b = $urandom; m_acc = 1'b0; m_valid = 1'b1;
        wait_ready(1'b1, "rmid_grant");
        @(posedge clk); #1 m_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rmid_en_mopa", w_matrix_en_mopa, 1'b0);
            chk("rmid_done", m_done, 1'b0);
            chk("rmid_busy", m_busy, 1'b0);
        end
        chk("rmid_rf", rf, mdl);
        mopa(32'h01020304, 32'h05060708, 1'b1, "rmid_after");

        // Random mix
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1)
                mopa($urandom, $urandom, 1'($urandom_range(0, 1)), "rnd_mopa");
            else
                swr(2'($urandom_range(0, 3)), $urandom, "rnd_swr");
        end
        chk("final_rf", rf, mdl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_mopa_ctrl.md
# matrix_mopa_ctrl

Controller that sequences and shares the 4×32-bit matrix register file between two requesters: the scalar pipeline's single-row write port and the outer-product-accumulate (MOPA) command path. It owns every write into the register file, computes a MOPA result one row per cycle into a staging buffer, and commits all four rows atomically. The register file's row outputs feed back into this block. No write from either requester can interleave with an in-flight MOPA.

## Interface
- No parameters. Matrix geometry is fixed: 4 rows × 4 byte lanes, with 8-bit elements.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  scalar write request
- s_index  in  2  target row
- s_data  in  32  row data
- s_ready  out  1  scalar request accepted this cycle
- m_valid  in  1  MOPA command request
- m_a  in  32  column vector a; byte i (bits 8i+7:8i) selects row i
- m_b  in  32  row vector b; byte j selects lane j
- m_acc  in  1  1 = accumulate into M, 0 = overwrite with the product
- m_ready  out  1  MOPA command accepted this cycle
- m_busy  out  1  MOPA in flight
- m_done  out  1  one-cycle pulse when the MOPA commit is issued
- M_in[3:0]  in  4×32  current register file rows
- w_matrix_index  out  2  scalar write row
- w_matrix_data  out  32  scalar write data
- w_matrix_en  out  1  scalar write strobe
- w_matrix_data_mopa[3:0]  out  4×32  MOPA commit rows
- w_matrix_en_mopa  out  1  MOPA commit strobe

## Operation
- FSM states:
  - IDLE
  - SWR: scalar write issue
  - CALC: MOPA row computation, 2-bit row counter r
  - COMMIT
- IDLE, arbitration:
  - Only one requester is granted per cycle. The grant is combinational on s_ready or m_ready, and a handshake is valid & ready.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not granted last. A last_grant bit is updated on every handshake and resets to "MOPA", so the scalar requester wins the first tie.
- Scalar handshake:
  - Latch s_index and s_data, then go to SWR.
  - SWR drives w_matrix_en=1 with the latched index and data for exactly one cycle, then returns to IDLE.
- MOPA handshake:
  - Latch m_a, m_b, m_acc, set r=0, and go to CALC.
- CALC, one cycle per row r:
  - For each lane j: stage[r].lane j = (m_acc ? M_in[r].lane j : 0) + low8(a_r × b_j).
  - All arithmetic is mod 256. There is no saturation and no carry between lanes.
  - After r=3, go to COMMIT.
- COMMIT:
  - w_matrix_en_mopa=1, w_matrix_data_mopa = stage, m_done=1, all for one cycle. Then return to IDLE.
- s_ready and m_ready are 0 in every state except IDLE.
  - Stimulus is therefore free to hold s_valid or m_valid across a MOPA; requests wait and are never dropped.
  - M_in is guaranteed stable during CALC because this block is the register file's only writer.
- m_busy=1 in CALC and COMMIT.
- w_matrix_en and w_matrix_en_mopa are never both 1.
- w_matrix_data_mopa holds the stage contents at all times. It only matters while the strobe is high.

## Timing
- Reset values:
  - State IDLE, r=0, last_grant=MOPA.
  - s_ready and m_ready follow the IDLE arbitration rules immediately after reset.
  - w_matrix_en=0, w_matrix_en_mopa=0, m_busy=0, m_done=0.
  - w_matrix_index=0, w_matrix_data=0, stage rows=0.
- Scalar: handshake in cycle T, w_matrix_en high in T+1, next grant possible in T+2. Maximum throughput is one scalar write every 2 cycles.
- MOPA: handshake in cycle T.
  - CALC rows 0–3 in T+1..T+4.
  - COMMIT, w_matrix_en_mopa and m_done in T+5.
  - The register file shows the new rows from T+6. IDLE, with a new grant possible, in T+6.
  - m_busy is high T+1..T+5.
- A request arriving during SWR, CALC or COMMIT is first granted in the next IDLE cycle, subject to the tie rule.
- Reset asserted mid-MOPA or mid-SWR:
  - The next cycle is IDLE, and the staged or latched data is discarded.
  - No write strobe and no m_done are emitted for the aborted operation.
- A requester deasserting valid before its handshake is legal; nothing is latched for it.

## Test plan
- Overwrite: m_a=0x04030201, m_b=0x01010101, m_acc=0 → rows 0–3 = 0x01010101, 0x02020202, 0x03030303, 0x04040404 in T+5. m_done is a single pulse and m_busy spans exactly 5 cycles.
- Accumulate: repeat the same command with m_acc=1 → rows become 0x02020202, 0x04040404, 0x06060606, 0x08080808.
- Wrap-around:
  - Overwrite with m_a=0x0000000F, m_b=0x00000011 → row0 = 0x000000FF.
  - Then accumulate with m_a=0x00000001, m_b=0x00000001 → row0 = 0x00000000 (mod-256 wrap), other lanes and rows unchanged.
- Tie fairness:
  - After reset, s_valid and m_valid are held together → scalar granted first (w_matrix_en=1, index 2, data 0xDEADBEEF), then the MOPA.
  - A second simultaneous pair → MOPA granted first.
- Blocking: s_valid held during a MOPA → s_ready stays 0 through T+5. The scalar write lands in T+7, after the commit, and its row is not corrupted.
- Reset mid-op: rst pulsed in T+3 of a MOPA → w_matrix_en_mopa and m_done are never asserted, M_in is unchanged, and a new MOPA completes normally.
